// File: rtl/decode_queue_if.sv
// Signal bundle between fetch (producer), decode_queue, and issue (consumer).
// The slave modport is the queue's own view of the bundle.
interface decode_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 2,
    parameter int unsigned CTL_W = 16
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IN_W-1:0]              in_valid;
    logic [IN_W-1:0][31:0]        in_instr;
    logic [IN_W-1:0][63:0]        in_pc;
    logic                         in_ready;
    logic [OUT_W-1:0]             out_valid;
    logic [OUT_W-1:0][31:0]       out_instr;
    logic [OUT_W-1:0][63:0]       out_pc;
    logic [OUT_W-1:0][63:0]       out_imm;
    logic [OUT_W-1:0][CTL_W-1:0]  out_ctl;
    logic [OUT_W-1:0]             out_illegal;
    logic                         out_ready;
    logic [CW-1:0]                count;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_ctl, out_illegal, count
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_ctl, out_illegal, count
    );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane decode-at-enqueue circular queue between fetch and issue (RV64I+M+Zicsr subset).
// ctl layout: 0 reg_write, 1 mem_access, 2 mem_write, 3 is_imm, 4 branch, 5 jal, 6 jalr,
// 7 word (32-bit ALU op), 8 csr, 9 lui, 10 auipc, 11 mul/div, 14:12 funct3, 15 alt (sub/sra).
module decode_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 2
) (
    input logic           clk,
    input logic           rst_n,
    input logic           flush,
    decode_queue_if.slave bus
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned CTL_W = 16;

    localparam logic [CW-1:0] FreeLim  = CW'(DEPTH - IN_W);
    localparam logic [CW-1:0] OutLanes = CW'(OUT_W);

    localparam int unsigned CtlRegWrite = 0;
    localparam int unsigned CtlMem      = 1;
    localparam int unsigned CtlMemWr    = 2;
    localparam int unsigned CtlImm      = 3;
    localparam int unsigned CtlBranch   = 4;
    localparam int unsigned CtlJal      = 5;
    localparam int unsigned CtlJalr     = 6;
    localparam int unsigned CtlWord     = 7;
    localparam int unsigned CtlCsr      = 8;
    localparam int unsigned CtlLui      = 9;
    localparam int unsigned CtlAuipc    = 10;
    localparam int unsigned CtlMul      = 11;
    localparam int unsigned CtlF3       = 12;
    localparam int unsigned CtlAlt      = 15;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpImm32  = 7'b0011011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpReg32  = 7'b0111011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;
    localparam logic [6:0] F7Mul  = 7'b0000001;

    typedef struct packed {
        logic             illegal;
        logic [CTL_W-1:0] ctl;
        logic [63:0]      imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic        ok;
        logic        has_f3;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  f6;
        logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
        f3     = ins[14:12];
        f7     = ins[31:25];
        f6     = ins[31:26];
        imm_i  = {{52{ins[31]}}, ins[31:20]};
        imm_s  = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b  = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u  = {{32{ins[31]}}, ins[31:12], 12'b0};
        imm_j  = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm_z  = {59'b0, ins[19:15]};
        d      = '0;
        ok     = 1'b0;
        has_f3 = 1'b1;
        case (ins[6:0])
            OpLui, OpAuipc: begin
                ok = 1'b1;
                has_f3 = 1'b0;
                d.imm = imm_u;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
                d.ctl[CtlLui] = (ins[6:0] == OpLui);
                d.ctl[CtlAuipc] = (ins[6:0] == OpAuipc);
            end
            OpJal: begin
                ok = 1'b1;
                has_f3 = 1'b0;
                d.imm = imm_j;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlJal] = 1'b1;
            end
            OpJalr: begin
                ok = (f3 == 3'b000);
                d.imm = imm_i;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
                d.ctl[CtlJalr] = 1'b1;
            end
            OpBranch: begin
                ok = (f3 != 3'b010) && (f3 != 3'b011);
                d.imm = imm_b;
                d.ctl[CtlBranch] = 1'b1;
            end
            OpLoad: begin
                ok = (f3 != 3'b111);
                d.imm = imm_i;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlMem] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
            end
            OpStore: begin
                ok = !f3[2];
                d.imm = imm_s;
                d.ctl[CtlMem] = 1'b1;
                d.ctl[CtlMemWr] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
            end
            OpImm: begin
                // RV64 shift amounts are 6 bits, so the function field is [31:26]
                case (f3)
                    3'b001:  ok = (f6 == 6'b000000);
                    3'b101:  ok = (f6 == 6'b000000) || (f6 == 6'b010000);
                    default: ok = 1'b1;
                endcase
                d.imm = imm_i;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
                d.ctl[CtlAlt] = (f3 == 3'b101) && ins[30];
            end
            OpImm32: begin
                ok = (f3 == 3'b000) || ((f3 == 3'b001) && (f7 == F7Zero)) ||
                     ((f3 == 3'b101) && ((f7 == F7Zero) || (f7 == F7Alt)));
                d.imm = imm_i;
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlImm] = 1'b1;
                d.ctl[CtlWord] = 1'b1;
                d.ctl[CtlAlt] = (f3 == 3'b101) && ins[30];
            end
            OpReg: begin
                ok = (f7 == F7Zero) || (f7 == F7Mul) ||
                     ((f7 == F7Alt) && ((f3 == 3'b000) || (f3 == 3'b101)));
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlMul] = (f7 == F7Mul);
                d.ctl[CtlAlt] = (f7 == F7Alt);
            end
            OpReg32: begin
                ok = ((f7 == F7Zero) && (f3 inside {3'd0, 3'd1, 3'd5})) ||
                     ((f7 == F7Alt) && (f3 inside {3'd0, 3'd5})) ||
                     ((f7 == F7Mul) && (f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7}));
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlWord] = 1'b1;
                d.ctl[CtlMul] = (f7 == F7Mul);
                d.ctl[CtlAlt] = (f7 == F7Alt);
            end
            OpSystem: begin
                // Only CSR ops; register forms carry no immediate (CSR address stays in instr)
                ok = (f3[1:0] != 2'b00);
                d.ctl[CtlRegWrite] = 1'b1;
                d.ctl[CtlCsr] = 1'b1;
                if (f3[2]) begin
                    d.imm = imm_z;
                    d.ctl[CtlImm] = 1'b1;
                end
            end
            default: ok = 1'b0;
        endcase
        if (has_f3) d.ctl[CtlF3 +: 3] = f3;
        if (!ok) d = '0;
        d.illegal = !ok;
        return d;
    endfunction

    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q    [DEPTH];
    dec_t          dec_q   [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic          in_rdy;
    logic [CW-1:0] n_enq, n_deq;
    logic [PW-1:0] wr_idx [IN_W];
    logic [PW-1:0] rd_idx [OUT_W];
    dec_t          dec_in [IN_W];

    // Ready depends on registered occupancy only, so no path from out_ready
    assign in_rdy = (count_q <= FreeLim);

    always_comb begin
        n_enq = '0;
        for (int j = 0; j < IN_W; j++) begin
            if (bus.in_valid[j]) n_enq = n_enq + CW'(1);
            wr_idx[j] = tail_q + PW'(j);
            dec_in[j] = decode(bus.in_instr[j]);
        end
        if (!in_rdy) n_enq = '0;
        n_deq = '0;
        if (bus.out_ready) n_deq = (count_q < OutLanes) ? count_q : OutLanes;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
                dec_q[i]   <= '0;
            end
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (in_rdy) begin
                for (int j = 0; j < IN_W; j++) begin
                    if (bus.in_valid[j]) begin
                        instr_q[wr_idx[j]] <= bus.in_instr[j];
                        pc_q[wr_idx[j]]    <= bus.in_pc[j];
                        dec_q[wr_idx[j]]   <= dec_in[j];
                    end
                end
            end
            head_q  <= head_q + PW'(n_deq);
            tail_q  <= tail_q + PW'(n_enq);
            count_q <= count_q + n_enq - n_deq;
        end
    end

    always_comb begin
        bus.out_valid   = '0;
        bus.out_instr   = '0;
        bus.out_pc      = '0;
        bus.out_imm     = '0;
        bus.out_ctl     = '0;
        bus.out_illegal = '0;
        for (int i = 0; i < OUT_W; i++) begin
            rd_idx[i]          = head_q + PW'(i);
            bus.out_valid[i]   = (count_q > CW'(i));
            bus.out_instr[i]   = instr_q[rd_idx[i]];
            bus.out_pc[i]      = pc_q[rd_idx[i]];
            bus.out_imm[i]     = dec_q[rd_idx[i]].imm;
            bus.out_ctl[i]     = dec_q[rd_idx[i]].ctl;
            bus.out_illegal[i] = dec_q[rd_idx[i]].illegal;
        end
    end

    assign bus.in_ready = in_rdy;
    assign bus.count    = count_q;
endmodule
